// File: rtl/gen_delay_queue_pkg.sv
// Shared definitions for the gen_delay_queue FIFO.
//   ptr_width() : index width for a ring of n entries (at least 1 bit)
//   count_t     : occupancy counter type (storage words + output register)
package gen_delay_queue_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] count_t;

    // Single-entry rings still get a 1-bit pointer so no zero-width vectors appear.
    function automatic int ptr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gen_delay_queue_mem.sv
// Storage ring for gen_delay_queue: NUM x WIDTH register array,
// one synchronous write port and one asynchronous read port.
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write index
//   i_wdata  : write word
//   i_raddr  : read index
//   o_rdata  : word at i_raddr (combinational)
module gen_delay_queue_mem #(
    parameter int WIDTH  = 8,
    parameter int NUM    = 5,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [NUM];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A read and write to the same slot in one cycle returns the old word,
    // which is what the head refill needs when the ring is full.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gen_delay_queue.sv
// gen_delay_queue: show-ahead synchronous FIFO with a registered head word.
// Capacity DEPTH words = (DEPTH-1)-entry storage ring + output register.
//   clk, rst : clock, asynchronous active-high reset
//   we, idata: write request and data
//   re       : pop request (effective only while oready=1)
//   wdata    : registered head word, valid when oready=1
//   oready   : head word valid
//   full     : count == DEPTH
//   empty    : count == 0
//   overflow : sticky dropped-write flag, present only when
//              GEN_DELAY_QUEUE_OVERFLOW_EN is defined
module gen_delay_queue
    import gen_delay_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] idata,
    input  logic             re,
    output logic [WIDTH-1:0] wdata,
    output logic             oready,
    output logic             full,
    output logic             empty
`ifdef GEN_DELAY_QUEUE_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NSTORE = DEPTH - 1;
    localparam int PTR_W  = ptr_width(NSTORE);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NSTORE - 1);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    count_t           r_count;
    logic [WIDTH-1:0] r_wdata;
    logic             r_oready;
    logic             r_full;
    logic             r_empty;

    logic             w_pop;
    logic             w_wr_ok;
    count_t           w_store_cnt;
    logic             w_store_nz;
    logic             w_load_st;
    logic             w_bypass;
    logic             w_mem_we;
    count_t           w_cnt_next;
    logic [WIDTH-1:0] w_rdata;

    assign w_pop       = re & r_oready;
    assign w_wr_ok     = we & (~r_full | w_pop);
    assign w_store_cnt = r_count - count_t'(r_oready);
    assign w_store_nz  = (w_store_cnt != '0);

    // The head is refilled from storage whenever it is vacated or was never
    // loaded. A write only bypasses storage when a pop would otherwise leave
    // the head empty; writes into an idle queue go through storage, giving
    // the one-cycle write-to-head latency.
    assign w_load_st   = (w_pop | ~r_oready) & w_store_nz;
    assign w_bypass    = w_pop & ~w_store_nz & w_wr_ok;
    assign w_mem_we    = w_wr_ok & ~w_bypass;
    assign w_cnt_next  = r_count + count_t'(w_wr_ok) - count_t'(w_pop);

    gen_delay_queue_mem #(
        .WIDTH  (WIDTH),
        .NUM    (NSTORE),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (idata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wdata  <= '0;
            r_oready <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_mem_we) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_load_st) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
                r_wdata  <= w_rdata;
                r_oready <= 1'b1;
            end else if (w_bypass) begin
                r_wdata  <= idata;
                r_oready <= 1'b1;
            end else if (w_pop) begin
                r_oready <= 1'b0;
            end
            r_count <= w_cnt_next;
            r_full  <= (w_cnt_next == count_t'(DEPTH));
            r_empty <= (w_cnt_next == '0);
        end
    end

`ifdef GEN_DELAY_QUEUE_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (we & r_full & ~w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

    assign wdata  = r_wdata;
    assign oready = r_oready;
    assign full   = r_full;
    assign empty  = r_empty;

endmodule

// File: tb/tb_gen_delay_queue.sv
module tb_gen_delay_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic [WIDTH-1:0] idata;
    logic             re;
    logic [WIDTH-1:0] wdata;
    logic             oready;
    logic             full;
    logic             empty;
`ifdef GEN_DELAY_QUEUE_OVERFLOW_EN
    logic             overflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gen_delay_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .idata  (idata),
        .re     (re),
        .wdata  (wdata),
        .oready (oready),
        .full   (full),
        .empty  (empty)
`ifdef GEN_DELAY_QUEUE_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_1_to_6();
        for (int v = 1; v <= 6; v++) begin
            we = 1'b1; idata = WIDTH'(v);
            tick();
            if (v == 5) check("fill_not_full_at5", 32'(full), 0);
        end
        we = 1'b0;
        check("fill_full_at6", 32'(full), 1);
        check("fill_oready", 32'(oready), 1);
    endtask

    initial begin
        logic [WIDTH-1:0] exp2 [4];
        exp2[0] = 8'd15; exp2[1] = 8'd17; exp2[2] = 8'd20; exp2[3] = 8'd25;

        rst = 1'b1; we = 1'b0; re = 1'b0; idata = '0;
        tick(); tick();
        check("rst_oready", 32'(oready), 0);
        check("rst_empty",  32'(empty),  1);
        check("rst_full",   32'(full),   0);
        check("rst_wdata",  32'(wdata),  0);
        rst = 1'b0;
        tick();

        // Case 2: 15, 17 back to back, then 20 and 25 two cycles apart.
        we = 1'b1; idata = 8'd15; tick();
        check("c2_latency_oready", 32'(oready), 0);
        idata = 8'd17; tick();
        check("c2_first_oready", 32'(oready), 1);
        check("c2_first_wdata",  32'(wdata),  15);
        we = 1'b0; tick();
        we = 1'b1; idata = 8'd20; tick();
        we = 1'b0; tick();
        we = 1'b1; idata = 8'd25; tick();
        we = 1'b0; tick();
        check("c2_full", 32'(full), 0);
        check("c2_wdata_hold", 32'(wdata), 15);

        // Case 3: drain in order.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("c3_oready%0d", i), 32'(oready), 1);
            check($sformatf("c3_pop%0d", i), 32'(wdata), 32'(exp2[i]));
            re = 1'b1;
            tick();
        end
        re = 1'b0;
        check("c3_oready_end", 32'(oready), 0);
        check("c3_empty_end",  32'(empty),  1);

        // Case 1: asynchronous reset mid-run, between clock edges.
        we = 1'b1; idata = 8'd5; tick(); tick();
        we = 1'b0;
        check("c1_pre_oready", 32'(oready), 1);
        #2 rst = 1'b1;
        #1;
        check("c1_async_oready", 32'(oready), 0);
        check("c1_async_empty",  32'(empty),  1);
        check("c1_async_full",   32'(full),   0);
        check("c1_async_wdata",  32'(wdata),  0);
        tick();
        rst = 1'b0;
        tick();

        // Case 4: fill, drop a write while full, drain 1..6.
        fill_1_to_6();
        we = 1'b1; idata = 8'd99; tick();
        we = 1'b0;
        check("c4_full_after_drop", 32'(full), 1);
`ifdef GEN_DELAY_QUEUE_OVERFLOW_EN
        check("c4_overflow", 32'(overflow), 1);
`endif
        for (int v = 1; v <= 6; v++) begin
            check($sformatf("c4_drain%0d", v), 32'(wdata), 32'(v));
            re = 1'b1;
            tick();
        end
        re = 1'b0;
        check("c4_oready_end", 32'(oready), 0);
        check("c4_empty_end",  32'(empty),  1);

        // Case 5: simultaneous write and pop while full.
        fill_1_to_6();
        check("c5_head", 32'(wdata), 1);
        we = 1'b1; idata = 8'd7; re = 1'b1; tick();
        we = 1'b0; re = 1'b0;
        check("c5_full_stays", 32'(full), 1);
        for (int v = 2; v <= 7; v++) begin
            check($sformatf("c5_drain%0d", v), 32'(wdata), 32'(v));
            re = 1'b1;
            tick();
        end
        re = 1'b0;
        check("c5_empty_end", 32'(empty), 1);

        // Case 6: streaming with re held, one word per clock.
        re = 1'b1;
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; idata = WIDTH'(40 + i);
            tick();
            if (i == 0) begin
                check("c6_latency", 32'(oready), 0);
            end else begin
                check($sformatf("c6_out%0d", i - 1), 32'(wdata), 32'(40 + i - 1));
                check($sformatf("c6_full%0d", i), 32'(full), 0);
            end
        end
        we = 1'b0;
        tick();
        check("c6_out_last", 32'(wdata), 47);
        check("c6_oready_last", 32'(oready), 1);
        tick();
        re = 1'b0;
        check("c6_oready_end", 32'(oready), 0);
        check("c6_empty_end",  32'(empty),  1);
        check("c6_wdata_hold", 32'(wdata),  47);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
